// File: rtl/regfile_write_ctrl.sv
// Owns the register file write port: clears all NUM_REGS entries after reset, then arbitrates A/B writebacks.
// Optional REGWR_RR_ARB_EN selects round-robin arbitration; otherwise A has fixed priority.
module regfile_write_ctrl #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  output logic              we,
  output logic [ADDR_W-1:0] writeRegister,
  output logic [DATA_W-1:0] writeData,
  output logic              init_done
);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] init_idx;
  logic              last_clear;

  assign last_clear = (state == S_INIT) && (init_idx == ADDR_W'(NUM_REGS - 1));

`ifdef REGWR_RR_ARB_EN
  // 0 = A favoured on the next contended cycle, 1 = B.
  logic rr_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= 1'b0;
    end else if (state == S_RUN && a_valid && b_valid) begin
      rr_ptr <= ~rr_ptr;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_INIT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    a_ready   = 1'b0;
    b_ready   = 1'b0;
    case (state)
      S_INIT: begin
        if (last_clear) begin
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
`ifdef REGWR_RR_ARB_EN
        if (a_valid && b_valid) begin
          a_ready = ~rr_ptr;
          b_ready = rr_ptr;
        end else begin
          a_ready = a_valid;
          b_ready = b_valid;
        end
`else
        a_ready = a_valid;
        b_ready = b_valid & ~a_valid;
`endif
      end
      default: state_nxt = S_INIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      init_idx      <= '0;
      we            <= 1'b0;
      writeRegister <= '0;
      writeData     <= '0;
      init_done     <= 1'b0;
    end else begin
      we <= 1'b0;
      if (state == S_INIT) begin
        we            <= 1'b1;
        writeRegister <= init_idx;
        writeData     <= '0;
        init_idx      <= init_idx + ADDR_W'(1);
        if (last_clear) begin
          init_done <= 1'b1;
        end
      end else if (a_ready) begin
        // r0 writes are acknowledged but never reach the register file.
        we            <= (a_addr != '0);
        writeRegister <= a_addr;
        writeData     <= a_data;
      end else if (b_ready) begin
        we            <= (b_addr != '0);
        writeRegister <= b_addr;
        writeData     <= b_data;
      end
    end
  end

endmodule

// File: tb/tb_regfile_write_ctrl.sv
// Directed bench for regfile_write_ctrl: every-cycle model comparison plus literal checkpoints.
module tb_regfile_write_ctrl;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          a_valid = 1'b0, b_valid = 1'b0;
  logic [AW-1:0] a_addr = '0, b_addr = '0;
  logic [DW-1:0] a_data = '0, b_data = '0;
  logic          a_ready, b_ready, we, init_done;
  logic [AW-1:0] writeRegister;
  logic [DW-1:0] writeData;

  int total = 0;
  int bad   = 0;

  regfile_write_ctrl #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
    .we(we), .writeRegister(writeRegister), .writeData(writeData), .init_done(init_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Returns {b_grant, a_grant}; ptr=0 favours A when both are valid.
  function automatic logic [1:0] grant(input logic av, input logic bv, input logic ptr);
    if (av && bv) begin
`ifdef REGWR_RR_ARB_EN
      return ptr ? 2'b10 : 2'b01;
`else
      return 2'b01;
`endif
    end
    if (av) return 2'b01;
    if (bv) return 2'b10;
    return 2'b00;
  endfunction

  // Model: edges since reset release decide the clear phase; afterwards a plain grant rule.
  int            m_edges = 0;
  logic          m_we = 1'b0, m_done = 1'b0, m_ptr = 1'b0;
  logic [AW-1:0] m_wr = '0;
  logic [DW-1:0] m_wd = '0;
  logic [1:0]    m_g;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_edges = 0; m_we = 1'b0; m_wr = '0; m_wd = '0; m_done = 1'b0; m_ptr = 1'b0;
    end else if (m_edges < NR) begin
      m_we = 1'b1;
      m_wr = m_edges[AW-1:0];
      m_wd = '0;
      if (m_edges == NR - 1) m_done = 1'b1;
      m_edges++;
    end else begin
      m_g = grant(a_valid, b_valid, m_ptr);
      m_we = 1'b0;
      if (m_g[0]) begin
        m_wr = a_addr; m_wd = a_data; m_we = (a_addr != 0);
      end else if (m_g[1]) begin
        m_wr = b_addr; m_wd = b_data; m_we = (b_addr != 0);
      end
      if (a_valid && b_valid) m_ptr = m_g[0];
    end
  end

  logic [1:0] exp_g;
  always @(negedge clk) begin
    exp_g = (rst || m_edges < NR) ? 2'b00 : grant(a_valid, b_valid, m_ptr);
    chk("a_ready", a_ready, exp_g[0]);
    chk("b_ready", b_ready, exp_g[1]);
    chk("we", we, m_we);
    chk("writeRegister", writeRegister, m_wr);
    chk("writeData", writeData, m_wd);
    chk("init_done", init_done, m_done);
  end

  int         we_cnt;
  logic [3:0] b_grants;
  logic [19:0] wr_seq;

  initial begin
    // Run 1: reset release with no requests.
    #12;
    chk("rst_we", we, 1'b0);
    chk("rst_done", init_done, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    we_cnt = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (we) we_cnt++;
      if (k == 1)  chk("first_clear_idx", writeRegister, 5'd0);
      if (k == 31) chk("done_before_last", init_done, 1'b0);
      if (k == 32) begin
        chk("last_clear_idx", writeRegister, 5'd31);
        chk("done_at_last", init_done, 1'b1);
      end
      if (k == 33) chk("we_after_init", we, 1'b0);
    end
    chk("init_we_count", we_cnt, 32);

    // Run 2: A valid held from reset.
    rst = 1'b1;
    a_valid = 1'b1; a_addr = 5'd5; a_data = 32'hDEADBEEF;
    #3;
    chk("rst_a_ready", a_ready, 1'b0);
    chk("rst_we2", we, 1'b0);
    chk("rst_done2", init_done, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    repeat (32) @(posedge clk);
    #1;
    chk("run_a_ready", a_ready, 1'b1);
    @(posedge clk); #1;
    chk("a_we", we, 1'b1);
    chk("a_wr", writeRegister, 5'd5);
    chk("a_wd", writeData, 32'hDEADBEEF);

    // Both valid for four cycles.
    a_addr = 5'd3; a_data = 32'h0000_00A3;
    b_valid = 1'b1; b_addr = 5'd7; b_data = 32'h0000_00B7;
    b_grants = '0; wr_seq = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      b_grants[i] = b_ready;
      @(posedge clk); #1;
      wr_seq[i*5 +: 5] = writeRegister;
    end
    a_valid = 1'b0; b_valid = 1'b0;
`ifdef REGWR_RR_ARB_EN
    chk("rr_grants", b_grants, 4'b1010);
    chk("rr_wr_seq", wr_seq, {5'd7, 5'd3, 5'd7, 5'd3});
`else
    chk("fixed_grants", b_grants, 4'b0000);
    chk("fixed_wr_seq", wr_seq, {5'd3, 5'd3, 5'd3, 5'd3});
`endif

    // B writes r0: acknowledged, dropped.
    b_valid = 1'b1; b_addr = 5'd0; b_data = 32'h12345678;
    @(negedge clk);
    chk("r0_b_ready", b_ready, 1'b1);
    @(posedge clk); #1;
    b_valid = 1'b0;
    chk("r0_we", we, 1'b0);
    chk("r0_wr", writeRegister, 5'd0);
    @(posedge clk); #1;

    // Accept a write, then reset while it is on the port.
    a_valid = 1'b1; a_addr = 5'd9; a_data = 32'h99;
    @(posedge clk); #1;
    a_valid = 1'b0;
    chk("pre_rst_we", we, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("midrun_rst_we", we, 1'b0);
    chk("midrun_rst_done", init_done, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("restart_idx0", writeRegister, 5'd0);
    chk("restart_we", we, 1'b1);
    @(posedge clk); #1;
    chk("restart_idx1", writeRegister, 5'd1);
    repeat (36) @(posedge clk);
    #1;
    chk("restart_done", init_done, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/regfile_write_ctrl.md
Name: regfile_write_ctrl

Overview:
- Controller that owns the single write port of the 32-entry register file.
- After reset, it sequences a clear of every register, one per cycle, so the register file needs no reset loop of its own.
- It then arbitrates the write port between two writeback requesters: A (ALU writeback) and B (load/multicycle writeback). Each uses a valid/ready handshake, and the accepted write is driven registered onto the register file write port.

Parameters:
- DATA_W, 32, width of write data.
- ADDR_W, 5, width of register index.
- NUM_REGS, 32, number of registers cleared during init; must be ≤ 2**ADDR_W.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- a_valid  input  1  requester A has a write pending.
- a_addr  input  ADDR_W  requester A destination register.
- a_data  input  DATA_W  requester A write data.
- a_ready  output  1  requester A write accepted this cycle (combinational).
- b_valid  input  1  requester B has a write pending.
- b_addr  input  ADDR_W  requester B destination register.
- b_data  input  DATA_W  requester B write data.
- b_ready  output  1  requester B write accepted this cycle (combinational).
- we  output  1  register file write enable (registered).
- writeRegister  output  ADDR_W  register file write index (registered).
- writeData  output  DATA_W  register file write data (registered).
- init_done  output  1  high once the clear sequence has completed (registered).

Behaviour:
- Reset (rst=1, asynchronous):
  - state=INIT, init index=0, we=0, writeRegister=0, writeData=0, init_done=0, round-robin pointer=A.
  - a_ready=0 and b_ready=0 while rst=1.
- State INIT:
  - a_ready=b_ready=0; requests are ignored and must be held by the requesters.
  - Each cycle, registers we=1, writeRegister=index, writeData=0, then index increments.
  - When the cycle with index=NUM_REGS-1 is issued, next state=RUN.
  - init_done rises on the same edge that drives the last clear; that clear is written at the following edge.
  - Total: NUM_REGS consecutive we pulses starting on the first edge after reset release.
- State RUN: arbitration is combinational each cycle.
  - Only a_valid: a_ready=1.
  - Only b_valid: b_ready=1.
  - Both valid: the requester named by the round-robin pointer gets ready=1 and the other gets 0. The pointer then flips to the loser on that edge; the pointer is unchanged when only one requester is valid or none is.
  - At most one ready is high in any cycle. A ready is never high without its valid.
- Accepted write (valid & ready at edge N):
  - At edge N the outputs register writeRegister=addr, writeData=data, and we=1 if addr≠0, else we=0.
  - A write to r0 is acknowledged but dropped.
  - The register file commits the write at edge N+1; latency is 1 cycle from acceptance to port drive.
- No acceptance: we=0 registered; writeRegister and writeData hold their previous values.
- Throughput: one write per cycle. A continuously valid requester loses at most one cycle in two while both are valid.
- Requesters must hold addr/data stable while valid and not ready.
- RUN is terminal until rst. Reset mid-INIT or mid-RUN restarts the full clear sequence; any in-flight accepted write is lost.

Optional Feature:
- Macro: REGWR_RR_ARB_EN.
- Defined: round-robin arbitration as described above.
- Not defined: fixed priority, A always wins when both are valid, and the pointer register is not implemented. All other behaviour is identical.

Test Plan:
- Reset release, no requests:
  - Exactly 32 cycles of we=1 with writeRegister 0,1,…,31 and writeData=0.
  - init_done=1 from the edge issuing index 31; we=0 afterwards.
- a_valid=1 held from reset:
  - a_ready=0 throughout INIT.
  - First cycle in RUN: a_ready=1.
  - Next cycle: we=1, writeRegister=a_addr (e.g. 5), writeData=a_data (e.g. 0xDEADBEEF).
- RUN, a_valid=b_valid=1 for 4 cycles with pointer=A (REGWR_RR_ARB_EN defined):
  - Grants A,B,A,B.
  - writeRegister sequence matches a_addr=3, b_addr=7, 3, 7 with one-cycle lag.
- Same stimulus without REGWR_RR_ARB_EN:
  - Grants A,A,A,A; b_ready stays 0.
- b_valid=1, b_addr=0, b_data=0x12345678:
  - b_ready=1.
  - Following cycle we=0, writeRegister=0.
- rst pulsed during RUN while a write was accepted the previous cycle:
  - we forced 0 immediately, init_done=0.
  - Clear sequence restarts from index 0 after release.
